// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core and a DMA/debug loader; grant is same-cycle from req.
// Writes finish in the grant cycle; a read holds the port MEM_LAT cycles and rvalid pulses in the last one.
module mem_port_arbiter #(
   parameter int AW       = 14,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [31:0]   cpu_wdata_i,
   input  logic [3:0]    cpu_wmask_i,
   output logic          cpu_gnt_o,
   output logic          cpu_rvalid_o,
   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [31:0]   dma_wdata_i,
   input  logic [3:0]    dma_wmask_i,
   output logic          dma_gnt_o,
   output logic          dma_rvalid_o,
   output logic [31:0]   rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   output logic [3:0]    mem_wmask_o,
   input  logic [31:0]   mem_rdata_i
);
   localparam int LW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(MAX_WAIT + 1);

   typedef enum logic {IDLE, READ_WAIT} state_t;

   state_t        state_q;
   logic [LW-1:0] lat_q;
   logic [SW-1:0] starve_q, starve_d;
   logic          owner_q;
   logic          live_q;

   logic active, free, dma_win, cpu_win, rv_last;

   // live_q keeps every strobe quiet for the first cycle out of reset
   assign active  = rst_n_i & live_q;
   assign free    = active & (state_q == IDLE);
   assign dma_win = free & dma_req_i & (~cpu_req_i | (starve_q == SW'(MAX_WAIT)));
   assign cpu_win = free & cpu_req_i & ~dma_win;
   assign rv_last = active & (state_q == READ_WAIT) & (lat_q == LW'(1));

   assign cpu_gnt_o    = cpu_win;
   assign dma_gnt_o    = dma_win;
   assign mem_en_o     = cpu_win | dma_win;
   assign mem_we_o     = (cpu_win & cpu_we_i) | (dma_win & dma_we_i);
   assign mem_addr_o   = ({AW{cpu_win}} & cpu_addr_i)  | ({AW{dma_win}} & dma_addr_i);
   assign mem_wdata_o  = ({32{cpu_win}} & cpu_wdata_i) | ({32{dma_win}} & dma_wdata_i);
   assign mem_wmask_o  = ({4{cpu_win}}  & cpu_wmask_i) | ({4{dma_win}}  & dma_wmask_i);
   assign cpu_rvalid_o = rv_last & ~owner_q;
   assign dma_rvalid_o = rv_last & owner_q;
   assign rdata_o      = rv_last ? mem_rdata_i : '0;

   always_comb begin
      starve_d = starve_q;
      if (dma_win) begin
         starve_d = '0;
      end else if (dma_req_i && (starve_q != SW'(MAX_WAIT))) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         starve_q <= '0;
         owner_q  <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         live_q   <= 1'b1;
         starve_q <= starve_d;
         case (state_q)
            IDLE: begin
               if (mem_en_o && !mem_we_o) begin
                  owner_q <= dma_win;
                  lat_q   <= LW'(MEM_LAT);
                  state_q <= READ_WAIT;
               end
            end
            READ_WAIT: begin
               lat_q <= lat_q - 1'b1;
               if (lat_q == LW'(1)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances, directed cases then random traffic,
// every cycle compared against a timestamp-based reference model with its own copy of memory.
module tb_mem_port_arbiter;
   localparam int AW       = 14;
   localparam int MAX_WAIT = 8;
   localparam int NW       = 1 << AW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [1:0]          dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [1:0]          mem_en, mem_we;
   logic [1:0][AW-1:0]  cpu_addr, dma_addr, mem_addr;
   logic [1:0][31:0]    cpu_wdata, dma_wdata, rdata, mem_wdata, mem_rdata;
   logic [1:0][3:0]     cpu_wmask, dma_wmask, mem_wmask;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] init_word(input int i, input int a);
      return (a * 32'h9E3779B1) ^ ((i != 0) ? 32'h5A5A0000 : 32'h0000A5A5);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem_arr [NW];
      logic [31:0] pipe [1:4];
      initial for (int a = 0; a < NW; a++) mem_arr[a] <= init_word(g, a);
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g])
            mem_arr[mem_addr[g]] <= merge(mem_arr[mem_addr[g]], mem_wdata[g], mem_wmask[g]);
         pipe[1] <= (mem_en[g] && !mem_we[g]) ? mem_arr[mem_addr[g]] : 32'hBAD0BAD0;
         for (int k = 2; k <= 4; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = pipe[LAT];

      mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
         .clk_i(clk), .rst_n_i(rst_n),
         .cpu_req_i(cpu_req[g]), .cpu_we_i(cpu_we[g]), .cpu_addr_i(cpu_addr[g]),
         .cpu_wdata_i(cpu_wdata[g]), .cpu_wmask_i(cpu_wmask[g]),
         .cpu_gnt_o(cpu_gnt[g]), .cpu_rvalid_o(cpu_rvalid[g]),
         .dma_req_i(dma_req[g]), .dma_we_i(dma_we[g]), .dma_addr_i(dma_addr[g]),
         .dma_wdata_i(dma_wdata[g]), .dma_wmask_i(dma_wmask[g]),
         .dma_gnt_o(dma_gnt[g]), .dma_rvalid_o(dma_rvalid[g]),
         .rdata_o(rdata[g]),
         .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]), .mem_wmask_o(mem_wmask[g]), .mem_rdata_i(mem_rdata[g])
      );
   end

   // reference model: port is busy until free_from, a pending read answers at rd_at
   logic [31:0] refmem [2][NW];
   int          cyc = 0;
   int          ready_from [2];
   int          free_from  [2];
   int          wait_c     [2];
   int          rd_at      [2];
   bit          rd_pend    [2];
   bit          rd_who     [2];
   logic [31:0] rd_exp     [2];

   logic        s_cg [2], s_dg [2], s_crv [2], s_drv [2], s_en [2];
   logic [31:0] s_rdata [2];
   logic [3:0]  s_wmask [2];

   bit in_rand = 0;
   int rdg_c [2], rdg_d [2], rv_c [2], rv_d [2], refused [2];

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
      end
   endtask

   task automatic eval(input int i);
      int lat;
      bit ready, free, cg, dg, crv, drv, we, any;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      logic [3:0]    wm;
      lat = (i == 0) ? 1 : 3;
      cg = 0; dg = 0; crv = 0; drv = 0; ready = 0; free = 0;
      if (rst_n) begin
         ready = (cyc >= ready_from[i]);
         free  = ready && (cyc >= free_from[i]);
         if (free && dma_req[i] && (!cpu_req[i] || wait_c[i] == MAX_WAIT)) dg = 1;
         else if (free && cpu_req[i]) cg = 1;
         if (ready && rd_pend[i] && rd_at[i] == cyc) begin
            crv = !rd_who[i];
            drv = rd_who[i];
         end
      end
      any = cg | dg;
      we  = cg ? cpu_we[i]    : dma_we[i];
      a   = cg ? cpu_addr[i]  : dma_addr[i];
      wd  = cg ? cpu_wdata[i] : dma_wdata[i];
      wm  = cg ? cpu_wmask[i] : dma_wmask[i];

      chk("cpu_gnt",    i, 32'(cpu_gnt[i]), 32'(cg));
      chk("dma_gnt",    i, 32'(dma_gnt[i]), 32'(dg));
      chk("gnt_onehot", i, 32'(cpu_gnt[i] & dma_gnt[i]), 32'd0);
      chk("cpu_rvalid", i, 32'(cpu_rvalid[i]), 32'(crv));
      chk("dma_rvalid", i, 32'(dma_rvalid[i]), 32'(drv));
      chk("mem_en",     i, 32'(mem_en[i]), 32'(any));
      chk("mem_we",     i, 32'(mem_we[i]), 32'(any & we));
      chk("mem_addr",   i, 32'(mem_addr[i]), any ? 32'(a) : 32'd0);
      chk("mem_wdata",  i, mem_wdata[i], any ? wd : 32'd0);
      chk("mem_wmask",  i, 32'(mem_wmask[i]), any ? 32'(wm) : 32'd0);
      if (crv || drv) chk("rdata", i, rdata[i], rd_exp[i]);

      s_cg[i] = cpu_gnt[i];  s_dg[i] = dma_gnt[i];
      s_crv[i] = cpu_rvalid[i]; s_drv[i] = dma_rvalid[i];
      s_en[i] = mem_en[i]; s_rdata[i] = rdata[i]; s_wmask[i] = mem_wmask[i];

      if (in_rand) begin
         if (cpu_gnt[i] && !cpu_we[i]) rdg_c[i]++;
         if (dma_gnt[i] && !dma_we[i]) rdg_d[i]++;
         if (cpu_rvalid[i]) rv_c[i]++;
         if (dma_rvalid[i]) rv_d[i]++;
         if (cpu_gnt[i] && dma_req[i]) refused[i]++;
         if (dma_gnt[i]) begin
            chk("dma_wait", i, 32'(refused[i] <= MAX_WAIT), 32'd1);
            refused[i] = 0;
         end
      end

      if (!rst_n) begin
         wait_c[i] = 0; rd_pend[i] = 0; ready_from[i] = cyc + 2; free_from[i] = 0;
      end else begin
         if (dg) wait_c[i] = 0;
         else if (dma_req[i] && wait_c[i] < MAX_WAIT) wait_c[i]++;
         if (crv || drv) rd_pend[i] = 0;
         if (any) begin
            if (we) refmem[i][a] = merge(refmem[i][a], wd, wm);
            else begin
               rd_pend[i] = 1; rd_at[i] = cyc + lat; rd_who[i] = dg;
               rd_exp[i] = refmem[i][a]; free_from[i] = cyc + lat + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) eval(i);
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (s_cg[i]) cpu_req[i] = 1'b0;
         if (s_dg[i]) dma_req[i] = 1'b0;
      end
   endtask

   initial begin
      int first_d;
      logic [31:0] exp_w;
      rst_n = 1'b0;
      cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
      dma_req = '0; dma_we = '0; dma_addr = '0; dma_wdata = '0; dma_wmask = '0;
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < NW; a++) refmem[i][a] = init_word(i, a);
         ready_from[i] = 0; free_from[i] = 0; wait_c[i] = 0; rd_at[i] = 0;
         rd_pend[i] = 0; rd_who[i] = 0; rd_exp[i] = '0;
         rdg_c[i] = 0; rdg_d[i] = 0; rv_c[i] = 0; rv_d[i] = 0; refused[i] = 0;
      end
      @(posedge clk);
      #1;

      // reset, then requests already waiting in the first cycle out of reset
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 14'h200; cpu_wdata[0] = 32'h01020304; cpu_wmask[0] = 4'hF;
      dma_req[1] = 1'b1; dma_we[1] = 1'b1; dma_addr[1] = 14'h200; dma_wdata[1] = 32'hA0B0C0D0; dma_wmask[1] = 4'hC;
      repeat (2) tick();
      chk("rst_mem_en", 0, 32'(s_en[0]), 32'd0);
      chk("rst_dma_gnt", 1, 32'(s_dg[1]), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_gnt", 0, 32'(s_cg[0]), 32'd0);
      chk("post_rst_en", 1, 32'(s_en[1]), 32'd0);
      tick();
      chk("first_gnt", 0, 32'(s_cg[0]), 32'd1);
      chk("first_gnt", 1, 32'(s_dg[1]), 32'd1);
      tick();

      // MEM_LAT=1 read: grant at t, rvalid at t+1, next grant at t+2
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 14'h010;
      tick();
      chk("t1_gnt", 0, 32'(s_cg[0]), 32'd1);
      chk("t1_en", 0, 32'(s_en[0]), 32'd1);
      cpu_req[0] = 1'b1; cpu_addr[0] = 14'h011;
      tick();
      chk("t1_rvalid", 0, 32'(s_crv[0]), 32'd1);
      chk("t1_rdata", 0, s_rdata[0], init_word(0, 32'h010));
      chk("t1_no_gnt_in_wait", 0, 32'(s_cg[0]), 32'd0);
      tick();
      chk("t1_next_gnt", 0, 32'(s_cg[0]), 32'd1);
      repeat (2) tick();

      // both write-requesting: eight CPU grants, DMA on the ninth, then CPU again
      first_d = -1;
      for (int k = 0; k < 10; k++) begin
         cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 14'h100; cpu_wdata[0] = 32'h11111111; cpu_wmask[0] = 4'hF;
         dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 14'h180; dma_wdata[0] = 32'h22222222; dma_wmask[0] = 4'hF;
         tick();
         if (s_dg[0] && first_d < 0) first_d = k;
         if (k == 9) chk("t2_cpu_after_dma", 0, 32'(s_cg[0]), 32'd1);
      end
      chk("t2_dma_slot", 0, 32'(first_d), 32'd8);
      cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
      tick();

      // partial DMA write then CPU read of the merged word
      dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 14'h020; dma_wdata[0] = 32'hDEADBEEF; dma_wmask[0] = 4'b0011;
      tick();
      chk("t3_dma_gnt", 0, 32'(s_dg[0]), 32'd1);
      chk("t3_wmask", 0, 32'(s_wmask[0]), 32'h3);
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 14'h020;
      tick();
      tick();
      exp_w = (init_word(0, 32'h020) & 32'hFFFF0000) | 32'h0000BEEF;
      chk("t3_rvalid", 0, 32'(s_crv[0]), 32'd1);
      chk("t3_merged", 0, s_rdata[0], exp_w);

      // MEM_LAT=3: DMA read blocks the CPU for three cycles
      dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 14'h030;
      tick();
      chk("t4_dma_gnt", 1, 32'(s_dg[1]), 32'd1);
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 14'h031;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t4_no_cpu_gnt", 1, 32'(s_cg[1]), 32'd0);
         chk("t4_dma_rvalid", 1, 32'(s_drv[1]), 32'(k == 3));
      end
      tick();
      chk("t4_cpu_gnt", 1, 32'(s_cg[1]), 32'd1);
      repeat (3) tick();
      chk("t4_cpu_rvalid", 1, 32'(s_crv[1]), 32'd1);
      chk("t4_cpu_rdata", 1, s_rdata[1], init_word(1, 32'h031));
      tick();

      // reset in the middle of a MEM_LAT=3 read aborts it
      dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 14'h040;
      tick();
      chk("t5_gnt", 1, 32'(s_dg[1]), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t5_en_after_rst", 1, 32'(s_en[1]), 32'd0);
      tick();
      chk("t5_no_rvalid", 1, 32'(s_drv[1]), 32'd0);
      chk("t5_no_cpu_rvalid", 1, 32'(s_crv[1]), 32'd0);
      repeat (2) tick();

      // random traffic with withdrawals
      in_rand = 1;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!cpu_req[i]) begin
               if ($urandom_range(0, 9) < 7) begin
                  cpu_req[i] = 1'b1; cpu_we[i] = 1'($urandom_range(0, 1));
                  cpu_addr[i] = AW'($urandom_range(0, 63)); cpu_wdata[i] = $urandom;
                  cpu_wmask[i] = 4'($urandom_range(0, 15));
               end
            end else if ($urandom_range(0, 19) == 0) cpu_req[i] = 1'b0;
            if (!dma_req[i]) begin
               if ($urandom_range(0, 9) < 5) begin
                  dma_req[i] = 1'b1; dma_we[i] = 1'($urandom_range(0, 1));
                  dma_addr[i] = AW'($urandom_range(0, 63)); dma_wdata[i] = $urandom;
                  dma_wmask[i] = 4'($urandom_range(0, 15));
               end
            end else if ($urandom_range(0, 19) == 0) dma_req[i] = 1'b0;
         end
         tick();
      end
      cpu_req = '0; dma_req = '0;
      repeat (6) tick();
      in_rand = 0;
      for (int i = 0; i < 2; i++) begin
         chk("cpu_rvalid_count", i, 32'(rv_c[i]), 32'(rdg_c[i]));
         chk("dma_rvalid_count", i, 32'(rv_d[i]), 32'(rdg_d[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
